// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//
// Bundle of signals between NREQ byte-stream requesters, the round-robin
// arbiter and the UART TX FIFO write port.
//
// Parameters
//   NREQ        number of requester lanes (2..8)
//
// Signals
//   req_valid   [NREQ]     lane i presents a byte
//   req_data    [8*NREQ]   lane i byte is bits [8*i+7 : 8*i]
//   req_last    [NREQ]     byte on lane i ends its packet
//   req_ready   [NREQ]     byte on lane i is accepted this cycle
//   tx_full                UART TX FIFO full flag
//   wr_uart                UART TX FIFO write strobe
//   w_data      [8]        byte written to the UART TX FIFO
//   busy                   a grant is active
//   grant_id    [3]        current or most recent grantee
//   timeout_err            one-cycle pulse when a grant is revoked by timeout
//
// Modports
//   slave   arbiter side (consumes requests and tx_full, drives the rest)
//   master  requester / FIFO side (the mirror image)
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_full;
    logic              wr_uart;
    logic [7:0]        w_data;
    logic              busy;
    logic [2:0]        grant_id;
    logic              timeout_err;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  tx_full,
        output req_ready,
        output wr_uart,
        output w_data,
        output busy,
        output grant_id,
        output timeout_err
    );

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output tx_full,
        input  req_ready,
        input  wr_uart,
        input  w_data,
        input  busy,
        input  grant_id,
        input  timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares the single UART transmit path between NREQ byte-stream requesters.
// Arbitration is round-robin and packet-locked: once a requester is granted it
// keeps the path until it transfers a byte marked last, so packets never
// interleave in the TX FIFO. A requester that stalls mid-packet for TIMEOUT
// consecutive cycles loses the grant and a one-cycle timeout_err is raised.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   TIMEOUT  idle SEND cycles tolerated mid-packet (1..2^TO_BIT-1)
//   TO_BIT   width of the timeout counter
//
// Ports
//   clk      system clock, rising edge
//   reset    asynchronous, active-low reset
//   bus      uart_tx_arbiter_if.slave: request lanes, FIFO write port, status
//
// Behaviour summary
//   IDLE  pick the first valid lane after last_grant (modulo NREQ), go SEND.
//         No byte is accepted in this cycle.
//   SEND  ready[grant] = ~tx_full. A byte moves when valid[grant] & ~tx_full;
//         wr_uart/w_data are combinational from that condition. A last byte
//         returns to IDLE; TIMEOUT consecutive cycles without valid[grant]
//         also return to IDLE with timeout_err in the following cycle.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255,
    parameter int TO_BIT  = 8
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Requester 0 must win the first arbitration after reset, so the
    // round-robin pointer starts on the highest lane.
    localparam logic [2:0]        LAST_GRANT_INIT = 3'(NREQ - 1);
    localparam logic [TO_BIT-1:0] TO_LIMIT        = TO_BIT'(TIMEOUT - 1);
    localparam logic [3:0]        NREQ_W          = 4'(NREQ);

    state_t            state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        last_grant_q, last_grant_d;
    logic [TO_BIT-1:0] to_cnt_q, to_cnt_d;
    logic              timeout_err_q, timeout_err_d;

    // Lanes padded out to eight so that a 3-bit grant index is always in
    // range regardless of NREQ; unused lanes read as idle.
    logic [7:0]        valid_pad;
    logic [7:0]        last_pad;
    logic [7:0]        lane_data [8];

    logic              arb_found;
    logic [2:0]        arb_idx;
    logic              xfer;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            if (gi < NREQ) begin : g_used
                assign valid_pad[gi] = bus.req_valid[gi];
                assign last_pad[gi]  = bus.req_last[gi];
                assign lane_data[gi] = bus.req_data[8*gi +: 8];
            end else begin : g_unused
                assign valid_pad[gi] = 1'b0;
                assign last_pad[gi]  = 1'b0;
                assign lane_data[gi] = 8'h00;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin search: first valid lane among last_grant+1 .. last_grant+NREQ
    // (mod NREQ). The last candidate is last_grant itself, so a lone requester
    // can be granted again immediately.
    // -------------------------------------------------------------------------
    always_comb begin : arb_search
        logic [3:0] cand;
        arb_found = 1'b0;
        arb_idx   = 3'd0;
        cand      = 4'd0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = {1'b0, last_grant_q} + 4'(off);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!arb_found && valid_pad[cand[2:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[2:0];
            end
        end
    end

    // A byte moves only while granted, the grantee is valid and the FIFO has
    // room. Keeping this combinational avoids writing on a stale full flag.
    assign xfer = (state_q == SEND) && valid_pad[grant_q] && !bus.tx_full;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin : next_state
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        to_cnt_d      = to_cnt_q;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d  = arb_idx;
                    state_d  = SEND;
                    to_cnt_d = '0;
                end
            end

            SEND: begin
                if (xfer) begin
                    to_cnt_d = '0;
                    if (last_pad[grant_q]) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end else if (!valid_pad[grant_q]) begin
                    // Stalled grantee: only cycles without valid count toward
                    // the timeout; FIFO back-pressure leaves the counter alone.
                    if (to_cnt_q == TO_LIMIT) begin
                        state_d       = IDLE;
                        last_grant_d  = grant_q;
                        to_cnt_d      = '0;
                        timeout_err_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_BIT'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_q       <= 3'd0;
            last_grant_q  <= LAST_GRANT_INIT;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = (state_q == SEND) && (grant_q == 3'(gi)) && !bus.tx_full;
        end
    endgenerate

    assign bus.wr_uart     = xfer;
    assign bus.w_data      = lane_data[grant_q];
    assign bus.busy        = (state_q == SEND);
    assign bus.grant_id    = grant_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locked arbiter that shares the single UART transmit path (`wr_uart` / `w_data` / `tx_full` of the `uart` top level) between NREQ byte-stream requesters. A grant is held from the first byte of a requester's packet until its `last` byte, so packets never interleave in the TX FIFO. A per-packet inactivity timeout reclaims the path from a requester that stalls mid-packet.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `TIMEOUT`, 255, idle cycles allowed mid-packet before the grant is revoked (1..2^TO_BIT-1).
- `TO_BIT`, 8, width of the timeout counter.
- `clk`  in  1  system clock; everything is clocked on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has a byte on its data lane.
- `req_data`  in  8*NREQ  byte lane i is bits [8*i+7 : 8*i].
- `req_last`  in  NREQ  the byte on lane i is the final byte of its packet.
- `req_ready`  out  NREQ  byte on lane i is accepted this cycle.
- `tx_full`  in  1  from the UART TX FIFO full flag.
- `wr_uart`  out  1  write strobe to the UART TX FIFO.
- `w_data`  out  8  byte to the UART TX FIFO.
- `busy`  out  1  a grant is active (state SEND).
- `grant_id`  out  3  index of the current or most recent grantee.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- State register: IDLE, SEND. Registered: `grant`, `last_grant`, `to_cnt`, `timeout_err`.
- Reset values: state=IDLE, grant=0, last_grant=NREQ-1 (requester 0 wins first), to_cnt=0, timeout_err=0. Resulting outputs: `req_ready`=0, `wr_uart`=0, `busy`=0, `grant_id`=0. `w_data` is don't-care while `wr_uart`=0.
- IDLE: if any `req_valid` is set, grant is the first valid index searching last_grant+1, last_grant+2, … modulo NREQ. State goes to SEND and to_cnt is cleared. No byte is accepted in IDLE.
- SEND: `req_ready[grant]` = `~tx_full`. All other ready bits are 0. A transfer occurs when `req_valid[grant] & ~tx_full`.
- On a transfer, `wr_uart` is high and `w_data` = lane[grant]. Both are combinational in the same cycle, so there is no stale-full write. to_cnt is cleared on every transfer.
- Transfer with `req_last[grant]`=1: the next state is IDLE and last_grant is set to grant.
- When `req_valid[grant]`=0 in SEND, to_cnt increments. Cycles with `tx_full`=1 and valid=1 do not count and hold to_cnt.
- Timeout: when to_cnt==TIMEOUT-1 and `req_valid[grant]`=0, the next state is IDLE, last_grant is set to grant, and `timeout_err` pulses for one cycle. The rest of that packet, if it arrives later, is arbitrated as a new packet.
- `grant_id` = grant, zero-extended to 3 bits. It holds its value in IDLE.
- Requesters that are not granted see ready=0 and must hold their data and valid.
- Changes to `req_valid` on non-granted lanes have no effect until the next IDLE arbitration.
- If `tx_full` and `req_last` occur together, there is no transfer and the grant stays locked.

## Timing
- Arbitration costs one IDLE cycle per packet. An L-byte packet with `tx_full`=0 and valid held takes L+1 cycles from the IDLE decision to the next IDLE.
- Back-to-back packets from different requesters have exactly one dead cycle between the last byte of one and the first byte of the next.
- Write latency from `req_valid` to `wr_uart` is 0 cycles while granted, and 1 cycle when a new arbitration is needed.
- The timeout fires on the TIMEOUT-th consecutive idle SEND cycle. `timeout_err` is high in the first IDLE cycle after revocation.
- Reset asserted mid-packet immediately forces IDLE and clears all outputs. Partial bytes already written to the FIFO are not recalled.

## Test plan
- Single requester: requester 1 sends 0xA5, 0x5A, 0x3C (last on 0x3C) with `tx_full`=0. Required: `wr_uart` high for 3 consecutive cycles after 1 IDLE cycle, `w_data` in order, `grant_id`=1, `busy` for 3 cycles.
- Round-robin: all 4 requesters valid with 2-byte packets from reset. Required: grant order 0,1,2,3,0. Exactly one dead cycle between packets. No interleaved bytes.
- Backpressure: `tx_full`=1 for 5 cycles mid-packet. Required: `req_ready`=0 and `wr_uart`=0 during that window, no timeout, and the byte is written on the first cycle `tx_full`=0.
- Timeout: with TIMEOUT=4, requester 2 sends 1 byte (not last) then drops valid. Required: `timeout_err` pulse after 4 idle cycles, `busy`=0, and requester 3 (valid) granted next.
- Last with full: `req_last` and `tx_full` are asserted in the same cycle. Required: grant is held and the byte is written once `tx_full` deasserts, followed by IDLE.
- Reset mid-packet: reset is asserted while requester 0 is on its 2nd byte. Required: all outputs 0 immediately. After release, requester 0 is granted first when requesters 0 and 1 are both valid.
